// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
// EX/MEM pipeline register with valid/ready handshakes on both sides.
// Carries writeback control, memory control, ALU result, store data and the
// destination register from EX to MEM.
//
// Handshake rule (both sides): a transfer happens at a rising clk_i edge
// where valid and ready are both 1. Valid, once raised, is held with stable
// payload until the transfer happens. Ready may be raised or dropped freely.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   flush_i      synchronous flush, drops every held entry and any input
//   in_valid_i   EX offers an instruction
//   in_ready_o   register accepts this cycle
//   wb_i/m_i/alu_i/st_data_i/rd_i   EX payload, m_i[0]=MemWrite m_i[1]=MemRead
//   out_valid_o  MEM-side entry valid
//   out_ready_i  MEM accepts the entry
//   wb_o/mem_write_o/mem_read_o     control, forced to 0 while out_valid_o=0
//   alu_o/st_data_o/rd_o            data, hold last value when invalid
//   stall_cnt_o  saturating count of cycles with out_valid_o && !out_ready_i
//   dbg_state_o  occupancy state (00 empty, 01 one entry, 11 full)
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int WB_W   = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [1:0]        m_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        dbg_state_o
);

  // Bit 0 = main entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   ready_q;
  logic   main_valid;
  logic   in_fire, out_fire;
  logic   load_main, load_skid, main_from_skid, clear_main;

  // Main entry drives the outputs directly.
  logic [WB_W-1:0]   wb_q;
  logic              mw_q, mr_q;
  logic [DATA_W-1:0] alu_q, st_q;
  logic [RD_W-1:0]   rd_q;

  // Skid entry holds the one instruction accepted while main was blocked.
  logic [WB_W-1:0]   sk_wb_q;
  logic [1:0]        sk_m_q;
  logic [DATA_W-1:0] sk_alu_q, sk_st_q;
  logic [RD_W-1:0]   sk_rd_q;

  logic [CNT_W-1:0]  stall_q;

  assign main_valid = state_q[0];
  assign out_fire   = main_valid && out_ready_i;
  // Flush wins over a same-edge input: the offer is not taken.
  assign in_fire    = in_valid_i && in_ready_o && !flush_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      // Registered ready keeps out_ready_i off the in_ready_o path.
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    clear_main     = 1'b0;
    if (flush_i) begin
      state_d    = ST_EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d    = ST_EMPTY;
            clear_main = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready_o  = (SKID != 0) ? ready_q : (!main_valid || out_ready_i);
    out_valid_o = main_valid;
    dbg_state_o = state_q;
  end

  // Payload registers. Control bits are cleared when main empties so the
  // squashed outputs come straight from flops; data bits are left to hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_q  <= '0;
      mw_q  <= 1'b0;
      mr_q  <= 1'b0;
      alu_q <= '0;
      st_q  <= '0;
      rd_q  <= '0;
    end else if (load_main) begin
      wb_q  <= wb_i;
      mw_q  <= m_i[0];
      mr_q  <= m_i[1];
      alu_q <= alu_i;
      st_q  <= st_data_i;
      rd_q  <= rd_i;
    end else if (main_from_skid) begin
      wb_q  <= sk_wb_q;
      mw_q  <= sk_m_q[0];
      mr_q  <= sk_m_q[1];
      alu_q <= sk_alu_q;
      st_q  <= sk_st_q;
      rd_q  <= sk_rd_q;
    end else if (clear_main) begin
      wb_q <= '0;
      mw_q <= 1'b0;
      mr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sk_wb_q  <= '0;
      sk_m_q   <= '0;
      sk_alu_q <= '0;
      sk_st_q  <= '0;
      sk_rd_q  <= '0;
    end else if (load_skid) begin
      sk_wb_q  <= wb_i;
      sk_m_q   <= m_i;
      sk_alu_q <= alu_i;
      sk_st_q  <= st_data_i;
      sk_rd_q  <= rd_i;
    end
  end

  // Back-pressure counter, saturating, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_o        = wb_q;
  assign mem_write_o = mw_q;
  assign mem_read_o  = mr_q;
  assign alu_o       = alu_q;
  assign st_data_o   = st_q;
  assign rd_o        = rd_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake. Replaces the fixed 32-bit stall-hold register.
- Carries writeback control, memory control, ALU result, store data and destination register from EX to MEM.
- Adds per-entry valid bits and bubble insertion with control squash, synchronous flush, an optional 2-entry skid buffer that breaks the ready path, and a saturating stall-cycle counter.
- Sits between the EX-stage ALU/forwarding mux and the data-memory stage.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- RD_W, 5, destination register index width.
- WB_W, 2, writeback control field width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; drops all held entries.
- in_valid_i  in  1  EX presents a valid instruction.
- in_ready_o  out  1  register can accept this cycle.
- wb_i  in  WB_W  writeback control.
- m_i  in  2  [0] = MemWrite, [1] = MemRead.
- alu_i  in  DATA_W  ALU result / address.
- st_data_i  in  DATA_W  forwarded store data.
- rd_i  in  RD_W  destination register.
- out_valid_o  out  1  MEM-side entry valid.
- out_ready_i  in  1  MEM accepts the entry.
- wb_o  out  WB_W  writeback control, squashed.
- mem_write_o  out  1  MemWrite, squashed.
- mem_read_o  out  1  MemRead, squashed.
- alu_o  out  DATA_W  ALU result.
- st_data_o  out  DATA_W  store data.
- rd_o  out  RD_W  destination register.
- stall_cnt_o  out  CNT_W  saturating count of back-pressure cycles.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - All entries invalid; all outputs 0; stall_cnt_o = 0.
  - in_ready_o = 1 after reset deasserts.
- Handshakes:
  - Input transfer: in_valid_i && in_ready_o at the rising edge.
  - Output transfer: out_valid_o && out_ready_i at the rising edge.
- Latency: one cycle from input transfer to out_valid_o when the block is empty.
- Squash: when out_valid_o = 0, wb_o, mem_write_o and mem_read_o are forced to 0. alu_o, st_data_o and rd_o hold their last value.
- SKID = 1, states by occupancy:
  - EMPTY:
    - Input transfer -> ONE (data into main).
  - ONE:
    - Input and output transfer together -> ONE (main reloaded).
    - Input transfer only -> FULL (data into skid).
    - Output transfer only -> EMPTY.
  - FULL:
    - in_ready_o = 0.
    - Output transfer -> ONE (skid moves to main in the same edge).
  - in_ready_o = !skid_valid, taken straight from a flop.
  - Ordering is strictly FIFO; no entry is dropped or duplicated.
- SKID = 0:
  - Single entry.
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Simultaneous input and output transfer reloads the entry.
- Flush:
  - At the next edge, all entries become invalid; outputs squash per the rule above.
  - Flush has priority over a simultaneous input transfer: the input is dropped, and EX must not count it as accepted.
  - in_ready_o = 1 in the cycle after the flush.
  - A flush while FULL empties both entries.
- Stall counter:
  - Increments on each edge where out_valid_o && !out_ready_i.
  - Saturates at all-ones; no wrap.
  - Not cleared by flush; only rst_i clears it.
- Outputs are registered only, except in_ready_o when SKID = 0.
- Reset mid-transfer discards all in-flight entries.

Test Plan:
- Reset then single op: wb_i = 2'b10, m_i = 2'b10, alu_i = 32'h0000_0040, rd_i = 5 with in_valid_i = 1, out_ready_i = 1 -> next cycle out_valid_o = 1, mem_read_o = 1, alu_o = 32'h40, rd_o = 5. One cycle later, with no new input, out_valid_o = 0 and all control outputs 0.
- SKID = 1 back-pressure: stream A = 1, B = 2, C = 3 with out_ready_i = 0 -> A and B accepted, in_ready_o = 0 before C. Then raise out_ready_i -> output order A, B, C; stall_cnt_o equals the number of blocked cycles.
- Flush while FULL, with in_valid_i = 1 on the same edge -> out_valid_o = 0, the input is not accepted, in_ready_o = 1 next cycle, and the next op passes normally.
- Squash check: a store with m_i = 2'b01 followed by a bubble (in_valid_i = 0) -> mem_write_o is 1 for exactly one cycle, and alu_o holds its value.
- SKID = 0, out_ready_i = 1 throughout, continuous stream of 100 ops -> one op per cycle, in_ready_o = 1 throughout, stall_cnt_o = 0.
- Counter saturation with CNT_W = 4: hold out_valid_o = 1, out_ready_i = 0 for 20 cycles -> stall_cnt_o = 4'hF and stays there.
